array_prod: RTL and testbench

//  Signed fixed-point dot product of two packed vectors of NUM_ELEM Q(QN).(QM) words.

---
 rtl/fxp_pkg.sv | 30 +++
 rtl/fxp_mac.sv | 28 ++
 rtl/array_prod.sv | 84 ++++++++
 tb/tb_array_prod.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Fixed-point constants, FSM state type and the shift+clamp helper shared by the MAC-based layers.
// Pure declarations: no latency and no flow control apply here.
package fxp_pkg;

  localparam int QN       = 6;
  localparam int QM       = 11;
  localparam int BITWIDTH = QN + QM + 1;
  localparam int ACC_W    = 2 * BITWIDTH + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = $signed((ACC_W'(1) << (BITWIDTH-1)) - ACC_W'(1));
  localparam logic signed [ACC_W-1:0] SAT_MIN = $signed(-(ACC_W'(1) << (BITWIDTH-1)));

  typedef enum logic {
    MAC  = 1'b0,
    DONE = 1'b1
  } prodState_t;

  // Floor-scale the accumulator back to Q(QN).(QM), then clamp to the representable range.
  function automatic logic [BITWIDTH-1:0] fxp_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> QM;
    if (shifted > SAT_MAX) begin
      return SAT_MAX[BITWIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[BITWIDTH-1:0];
    end
    return shifted[BITWIDTH-1:0];
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate register; adds a*b on every enabled edge, cleared by reset.
// One-cycle update latency; no backpressure, the caller gates with macEn.
module fxp_mac
  import fxp_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       macEn,
  input  logic signed [BITWIDTH-1:0] opA,
  input  logic signed [BITWIDTH-1:0] opB,
  output logic signed [ACC_W-1:0]    acc
);

  logic signed [2*BITWIDTH-1:0] prod;
  logic        [ACC_W-1:0]      prodExt;

  assign prod    = opA * opB;
  assign prodExt = {{(ACC_W - 2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (macEn) begin
      acc <= acc + $signed(prodExt);
    end
  end

endmodule

// File: rtl/array_prod.sv
// Sequential signed dot product of two packed vectors, one MAC per clock, sticky dataReady.
// dataReady rises NUM_ELEM+1 edges after reset release; no backpressure, inputs held until done.
module array_prod
  import fxp_pkg::*;
#(
  parameter int NUM_ELEM = 8,
  parameter int VEC_W    = NUM_ELEM * BITWIDTH,
  parameter int IDX_W    = $clog2(NUM_ELEM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [VEC_W-1:0]    vecA,
  input  logic [VEC_W-1:0]    vecB,
  output logic                dataReady,
  output logic [BITWIDTH-1:0] result
);

  prodState_t               state;
  prodState_t               nextState;
  logic [IDX_W-1:0]         idx;
  logic                     macEn;
  logic                     loadResult;
  logic signed [BITWIDTH-1:0] elemA;
  logic signed [BITWIDTH-1:0] elemB;
  logic signed [ACC_W-1:0]  acc;

  assign elemA = $signed(vecA[idx*BITWIDTH +: BITWIDTH]);
  assign elemB = $signed(vecB[idx*BITWIDTH +: BITWIDTH]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= MAC;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    macEn      = 1'b0;
    loadResult = 1'b0;
    case (state)
      MAC: begin
        macEn = 1'b1;
        if (idx == IDX_W'(NUM_ELEM - 1)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        // Only the first DONE edge captures; later edges leave everything frozen.
        loadResult = !dataReady;
      end
      default: nextState = MAC;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (macEn) begin
      idx <= idx + IDX_W'(1);
    end
  end

  fxp_mac uMac (
    .clock (clock),
    .reset (reset),
    .macEn (macEn),
    .opA   (elemA),
    .opB   (elemB),
    .acc   (acc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      dataReady <= 1'b0;
    end else if (loadResult) begin
      result    <= fxp_sat(acc);
      dataReady <= 1'b1;
    end
  end

endmodule

// File: tb/tb_array_prod.sv
// Directed and random checks of array_prod against an arithmetic dot-product reference.
module tb_array_prod;

  localparam int N  = 8;
  localparam int BW = 18;
  localparam int VW = N * BW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [VW-1:0] vecA  = '0;
  logic [VW-1:0] vecB  = '0;
  logic          dataReady;
  logic [BW-1:0] result;

  int nAsserts = 0;
  int nFails   = 0;

  array_prod #(.NUM_ELEM(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .vecA      (vecA),
    .vecB      (vecB),
    .dataReady (dataReady),
    .result    (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    nAsserts++;
    assert (got === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [BW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  // Reference: integer sum of products, wrapped to a 37-bit signed accumulator,
  // floor-divided by 2^11 and clamped to the 18-bit signed range.
  function automatic logic [BW-1:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint sum = 0;
    longint q;
    logic signed [BW-1:0] ea, eb;
    for (int i = 0; i < N; i++) begin
      ea = a[i*BW +: BW];
      eb = b[i*BW +: BW];
      sum += longint'(ea) * longint'(eb);
    end
    sum = (sum <<< 27) >>> 27;
    q = sum >>> 11;
    if (q > 131071) q = 131071;
    if (q < -131072) q = -131072;
    return q[BW-1:0];
  endfunction

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_ready", {17'b0, dataReady}, 18'h0);
    check("reset_result", result, 18'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Release reset, watch dataReady on every edge up to the expected completion edge.
  task automatic runCheck(input string tag, input logic [BW-1:0] exp);
    pulseReset();
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clock);
      #1;
      check({tag, "_ready"}, {17'b0, dataReady}, (k == N + 1) ? 18'h1 : 18'h0);
    end
    check({tag, "_result"}, result, exp);
  endtask

  initial begin
    logic [BW-1:0] held;

    vecA = fill(18'h00800); vecB = fill(18'h00400);
    runCheck("half", 18'h02000);

    vecA = fill(18'h3F800); vecB = fill(18'h00800);
    runCheck("neg", 18'h3C000);

    vecA = fill(18'h0F800); vecB = fill(18'h0F800);
    runCheck("satpos", 18'h1FFFF);
    vecB = fill(18'h30800);
    runCheck("satneg", 18'h20000);

    vecA = '0; vecB = '0;
    vecA[BW-1:0] = 18'h00001; vecB[BW-1:0] = 18'h00001;
    runCheck("floor_pos", 18'h00000);
    vecA[BW-1:0] = 18'h3FFFF;
    runCheck("floor_neg", 18'h3FFFF);

    // Abort after edge 4, then a full recompute must match the uninterrupted value.
    vecA = fill(18'h00C00); vecB = fill(18'h3FA00);
    pulseReset();
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready", {17'b0, dataReady}, 18'h0);
    check("abort_result", result, 18'h0);
    runCheck("restart", model(vecA, vecB));

    // Result is frozen once done, whatever the inputs do afterwards.
    held = model(vecA, vecB);
    vecA = fill(18'h05555);
    repeat (20) @(posedge clock);
    #1;
    check("hold_ready", {17'b0, dataReady}, 18'h1);
    check("hold_result", result, held);

    // Immediate async clear from the done state.
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("clr_ready", {17'b0, dataReady}, 18'h0);
    check("clr_result", result, 18'h0);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t < 6) begin
          vecA[i*BW +: BW] = BW'($urandom);
          vecB[i*BW +: BW] = BW'($urandom);
        end else begin
          vecA[i*BW +: BW] = BW'($signed($urandom_range(0, 8191)) - 4096);
          vecB[i*BW +: BW] = BW'($signed($urandom_range(0, 8191)) - 4096);
        end
      end
      runCheck("random", model(vecA, vecB));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
